cobs_packet_arbiter: RTL and testbench
======================================

COBS_PACKET_ARBITER -- requirements
Module: cobs_packet_arbiter

Interface
REQ-001 Parameter NUM_SOURCES, default 2: number of raw AXI-Stream requesters sharing one COBS encoder, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte-wide stream data.
REQ-003 Parameter MAX_PAYLOAD, default 253: maximum payload beats per output packet.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_tdata  input  NUM_SOURCES*DATA_WIDTH  per-source data; source i occupies bits [i*8 +: 8].
REQ-007 s_tvalid  input  NUM_SOURCES  per-source valid.
REQ-008 s_tlast  input  NUM_SOURCES  per-source end of packet.
REQ-009 s_tready  output  NUM_SOURCES  per-source ready.
REQ-010 m_tdata  output  DATA_WIDTH  data to the COBS encoder raw stream.
REQ-011 m_tvalid  output  1  output valid.
REQ-012 m_tlast  output  1  output end of packet.
REQ-013 m_tuser  output  1  tied 0.
REQ-014 m_tready  input  1  encoder ready.
REQ-015 overflow  output  1  one-cycle pulse when a packet is truncated at MAX_PAYLOAD.

Function
REQ-016 States IDLE, HEADER, PAYLOAD, DRAIN; register grant index and round-robin pointer rr_ptr.
REQ-017 IDLE: m_tvalid=0, all s_tready=0; if any s_tvalid, grant the first asserted source searching upward from rr_ptr with wrap, and go to HEADER next cycle; else stay.
REQ-018 HEADER: m_tvalid=1, m_tdata=grant index zero-extended, m_tlast=0, all s_tready=0; on m_tvalid&&m_tready go to PAYLOAD, clear beat counter.
REQ-019 PAYLOAD: combinational pass-through, zero added latency: m_tdata=s_tdata[grant], m_tvalid=s_tvalid[grant], s_tready[grant]=m_tready, other s_tready=0.
REQ-020 PAYLOAD: m_tlast = s_tlast[grant] OR (beat counter == MAX_PAYLOAD-1); counter increments per accepted beat.
REQ-021 PAYLOAD handshake with s_tlast[grant]=1: go to IDLE, rr_ptr = grant+1 modulo NUM_SOURCES.
REQ-022 PAYLOAD handshake at counter MAX_PAYLOAD-1 with s_tlast[grant]=0: m_tlast=1 on that beat, overflow=1 for that cycle, go to DRAIN.
REQ-023 DRAIN: m_tvalid=0, s_tready[grant]=1, discard beats; on s_tvalid[grant]&&s_tlast[grant] go to IDLE, rr_ptr = grant+1 wrapped.
REQ-024 Header and payload outputs SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-025 s_tvalid[grant] deasserting mid-packet: m_tvalid=0, state and counter hold.
REQ-026 Only one source granted at a time; sources not granted never see s_tready=1.
REQ-027 A lone persistent requester is regranted on consecutive packets, one IDLE cycle between packets.
REQ-028 Single-beat payload (s_tlast on first beat) is legal: output is header plus one byte.

Reset
REQ-029 On rst: state=IDLE, rr_ptr=0, grant=0, counter=0; m_tvalid, m_tlast, overflow, all s_tready = 0; takes effect immediately, also mid-packet.
REQ-030 After rst release, first arbitration occurs on the first rising edge with any s_tvalid set.

Verification
REQ-031 Source0 sends 0x69,0x6A (last), m_tready=1 -> output 0x00,0x69,0x6A with m_tlast on 0x6A; after COBS encode: 0x01,0x03,0x69,0x6A,0x00.
REQ-032 Both sources valid continuously, each 2-byte packets -> grants alternate 0,1,0,1; headers 0x00,0x01,0x00,0x01.
REQ-033 MAX_PAYLOAD=4, source1 sends 6 bytes -> output header 0x01 plus 4 bytes, m_tlast on the 4th, overflow one cycle, 2 bytes drained, next grant source0 if valid.
REQ-034 m_tready toggled every other cycle during a 3-byte packet -> m_tdata stable while stalled, no byte lost or duplicated.
REQ-035 rst asserted after 1 payload byte -> outputs 0 immediately; after release, source0 packet restarts with header 0x00.
REQ-036 s_tvalid[grant] gaps of 3 cycles mid-packet -> m_tvalid low for those cycles, state held, byte order preserved.

Source files
------------

// File: rtl/cobs_packet_arbiter.sv
// Round-robin arbiter that merges NUM_SOURCES raw byte streams into one COBS
// encoder input, prefixing each packet with the granted source index.
module cobs_packet_arbiter #(
  parameter int unsigned NUM_SOURCES = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_PAYLOAD = 253
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  output logic [NUM_SOURCES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic                              m_tuser,
  input  logic                              m_tready,
  output logic                              overflow
);

  localparam int unsigned GW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_PAYLOAD - 1);
  localparam logic [GW-1:0] LAST_SRC  = GW'(NUM_SOURCES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_nxt;
  logic [GW-1:0]   grant_inc;
  logic [GW-1:0]   arb_idx;
  logic            arb_found;
  int unsigned     cand;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [DATA_WIDTH-1:0] src_data [NUM_SOURCES];
  logic            g_valid;
  logic            g_last;
  logic            at_max;
  logic            beat_ok;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign g_valid   = s_tvalid[grant];
  assign g_last    = s_tlast[grant];
  assign at_max    = (beat_cnt == LAST_BEAT);
  assign beat_ok   = g_valid & m_tready;
  assign grant_inc = (grant == LAST_SRC) ? '0 : grant + GW'(1);
  assign m_tuser   = 1'b0;

  // First requesting source at or above rr_ptr, wrapping past the top index.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_SOURCES) begin
        cand = cand - NUM_SOURCES;
      end
      if (!arb_found && s_tvalid[GW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(cand);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = HEADER;
          grant_nxt = arb_idx;
        end
      end
      HEADER: begin
        if (m_tready) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = '0;
        end
      end
      PAYLOAD: begin
        if (beat_ok) begin
          if (g_last) begin
            state_nxt = IDLE;
            rr_nxt    = grant_inc;
            cnt_nxt   = '0;
          end else if (at_max) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Overlong remainder is swallowed until the source closes its packet.
        if (g_valid && g_last) begin
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; payload is a zero-latency pass-through of the granted source.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    overflow = 1'b0;
    s_tready = '0;
    case (state)
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = DATA_WIDTH'(grant);
      end
      PAYLOAD: begin
        m_tvalid        = g_valid;
        m_tdata         = src_data[grant];
        m_tlast         = g_last | at_max;
        s_tready[grant] = m_tready;
        overflow        = beat_ok & at_max & ~g_last;
      end
      DRAIN: begin
        s_tready[grant] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cobs_packet_arbiter.sv
// Directed and randomized bench for cobs_packet_arbiter, checked against a
// queue-based packet-level model of the arbitration and truncation rules.
module tb_cobs_packet_arbiter;

  localparam int unsigned NS   = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tuser;
  logic              m_tready;
  logic              overflow;

  cobs_packet_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } sbeat_t;
  typedef struct packed { logic [7:0] d; logic l; logic o; logic [31:0] cyc; } obeat_t;
  typedef logic [7:0] byte_q_t [$];

  sbeat_t      src_q [NS][$];
  sbeat_t      mdl_q [NS][$];
  obeat_t      act_q [$];
  obeat_t      exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int          m_rr = 0;
  int          ready_mode = 0;
  int          gap_mode = 0;
  logic [NS-1:0] mid = '0;
  int          gap_left [NS] = '{default: 0};
  logic        in_pkt = 1'b0;
  int          cur_src = 0;
  int          low_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d = '0;
  logic        prev_l = 1'b0;
  logic [NS-1:0] hs_src = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void cobs_enc(input byte_q_t raw, output byte_q_t enc);
    int code_idx;
    logic [7:0] code;
    enc = {};
    enc.push_back(8'h00);
    code_idx = 0;
    code = 8'd1;
    foreach (raw[k]) begin
      if (raw[k] == 8'h00) begin
        enc[code_idx] = code;
        code_idx = enc.size();
        enc.push_back(8'h00);
        code = 8'd1;
      end else begin
        enc.push_back(raw[k]);
        code = code + 8'd1;
      end
    end
    enc[code_idx] = code;
    enc.push_back(8'h00);
  endfunction

  // Output monitor and per-cycle protocol checks, sampled between edges.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      hs_src = s_tvalid & s_tready;
      if (!rst) begin
        chk("tready_grant", 64'(s_tready & ~(NS'(1) << cur_src)), 64'd0);
        if (m_tvalid && !in_pkt) chk("tready_hdr", 64'(s_tready), 64'd0);
        if (prev_stall) begin
          chk("stall_valid", 64'(m_tvalid), 64'd1);
          chk("stall_data", 64'(m_tdata), 64'(prev_d));
          chk("stall_last", 64'(m_tlast), 64'(prev_l));
        end
        if (m_tvalid && m_tready) begin
          act_q.push_back('{d: m_tdata, l: m_tlast, o: overflow, cyc: cyc});
          if (!in_pkt) begin
            in_pkt = 1'b1;
            cur_src = int'(m_tdata);
          end else if (m_tlast) begin
            in_pkt = 1'b0;
          end
        end else begin
          chk("ovf_quiet", 64'(overflow), 64'd0);
          if (in_pkt && !m_tvalid) low_cnt++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  end

  // Source drivers: valid is held until accepted; gaps only inside a packet.
  initial begin
    logic [NS-1:0]    nv;
    logic [NS-1:0]    nl;
    logic [NS*DW-1:0] nd;
    sbeat_t           b;
    logic             v;
    forever begin
      @(posedge clk);
      #1;
      nv = '0; nl = '0; nd = '0;
      for (int i = 0; i < NS; i++) begin
        if (hs_src[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid[i] = !b.l;
          if (mid[i] && gap_mode == 2) gap_left[i] = 3;
        end
        if (src_q[i].size() == 0) v = 1'b0;
        else if (s_tvalid[i] && !hs_src[i]) v = 1'b1;
        else if (!mid[i]) v = 1'b1;
        else if (gap_mode == 2) begin
          if (gap_left[i] > 0) begin
            v = 1'b0;
            gap_left[i]--;
          end else v = 1'b1;
        end else if (gap_mode == 1) v = ($urandom_range(0, 3) != 0);
        else v = 1'b1;
        nv[i] = v;
        if (src_q[i].size() > 0) begin
          nd[i*DW +: DW] = src_q[i][0].d;
          nl[i] = src_q[i][0].l;
        end
      end
      s_tvalid = nv;
      s_tdata  = nd;
      s_tlast  = nl;
      case (ready_mode)
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b1;
      endcase
    end
  end

  task automatic start_scn();
    @(negedge clk);
    #1;
    act_q.delete();
    exp_q.delete();
    low_cnt = 0;
    c0 = cyc;
  endtask

  task automatic add_pkt(input int s, input int len, input logic [7:0] first, input bit rnd);
    sbeat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = rnd ? 8'($urandom) : first + 8'(k);
      b.l = (k == len - 1);
      src_q[s].push_back(b);
      mdl_q[s].push_back(b);
    end
  endtask

  // Packet-level model: round-robin over sources with pending packets,
  // header = source index, payload truncated to MAXP with overflow on the cut.
  task automatic build_exp();
    int g;
    int n;
    sbeat_t b;
    while (1) begin
      g = -1;
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (m_rr + k) % NS;
        if (g < 0 && mdl_q[c].size() > 0) g = c;
      end
      if (g < 0) break;
      exp_q.push_back('{d: 8'(g), l: 1'b0, o: 1'b0, cyc: 32'd0});
      n = 0;
      do begin
        b = mdl_q[g].pop_front();
        n++;
        if (n <= MAXP)
          exp_q.push_back('{d: b.d, l: b.l || (n == MAXP), o: (n == MAXP) && !b.l, cyc: 32'd0});
      end while (!b.l);
      m_rr = (g + 1) % NS;
    end
  endtask

  function automatic bit srcs_busy();
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic finish_scn(input string tag);
    int guard;
    guard = 0;
    while ((act_q.size() < exp_q.size() || srcs_busy()) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done"}, 64'(guard < 3000), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      chk($sformatf("%s_data%0d", tag, k), 64'(act_q[k].d), 64'(exp_q[k].d));
      chk($sformatf("%s_last%0d", tag, k), 64'(act_q[k].l), 64'(exp_q[k].l));
      chk($sformatf("%s_ovf%0d", tag, k), 64'(act_q[k].o), 64'(exp_q[k].o));
    end
  endtask

  initial begin
    byte_q_t raw;
    byte_q_t enc;
    logic [63:0] packed_enc;
    int ovf_cnt;
    int guard;

    rst = 1'b1;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mtvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_mtlast", 64'(m_tlast), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("tuser", 64'(m_tuser), 64'd0);
    rst = 1'b0;

    // Two sources continuously valid: grants alternate 0,1,0,1.
    start_scn();
    add_pkt(0, 2, 8'h01, 1'b0); add_pkt(0, 2, 8'h03, 1'b0);
    add_pkt(1, 2, 8'h11, 1'b0); add_pkt(1, 2, 8'h13, 1'b0);
    build_exp();
    finish_scn("alt");
    if (act_q.size() >= 12) begin
      chk("alt_hdr_seq", {32'd0, act_q[0].d, act_q[3].d, act_q[6].d, act_q[9].d}, 64'h00010001);
    end

    // Basic two-byte packet, arbitration latency and COBS framing of the output.
    start_scn();
    add_pkt(0, 2, 8'h69, 1'b0);
    build_exp();
    finish_scn("basic");
    if (act_q.size() > 0) chk("basic_latency", 64'(act_q[0].cyc - c0), 64'd2);
    raw = {};
    foreach (act_q[k]) raw.push_back(act_q[k].d);
    cobs_enc(raw, enc);
    packed_enc = '0;
    foreach (enc[k]) packed_enc = {packed_enc[55:0], enc[k]};
    chk("basic_cobs", packed_enc, 64'h0103696A00);

    // Source1 overlong packet truncated at MAXP, then source0 granted.
    start_scn();
    add_pkt(1, 6, 8'hA0, 1'b0);
    add_pkt(0, 2, 8'h10, 1'b0);
    build_exp();
    finish_scn("trunc");
    ovf_cnt = 0;
    foreach (act_q[k]) if (act_q[k].o) ovf_cnt++;
    chk("trunc_ovf_pulses", 64'(ovf_cnt), 64'd1);

    // Encoder ready toggling every cycle during a 3-byte packet.
    ready_mode = 1;
    start_scn();
    add_pkt(2, 3, 8'h30, 1'b0);
    build_exp();
    finish_scn("stall");
    ready_mode = 0;

    // Three-cycle source gaps mid-packet.
    gap_mode = 2;
    start_scn();
    add_pkt(0, 3, 8'h50, 1'b0);
    build_exp();
    finish_scn("gaps");
    chk("gaps_low_cycles", 64'(low_cnt), 64'd6);
    gap_mode = 0;

    // Lone requester: single-beat packet then two-byte packet, one idle between.
    start_scn();
    add_pkt(1, 1, 8'hC0, 1'b0);
    add_pkt(1, 2, 8'hC8, 1'b0);
    build_exp();
    finish_scn("lone");
    if (act_q.size() >= 3) chk("lone_regrant_gap", 64'(act_q[2].cyc - act_q[1].cyc), 64'd2);

    // Randomized traffic with random ready and random source gaps.
    for (int r = 0; r < 8; r++) begin
      ready_mode = 2;
      gap_mode = 1;
      start_scn();
      for (int s = 0; s < NS; s++) begin
        int np;
        np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) add_pkt(s, int'($urandom_range(1, 7)), 8'h00, 1'b1);
      end
      build_exp();
      finish_scn($sformatf("rnd%0d", r));
    end
    ready_mode = 0;
    gap_mode = 0;

    // Leave the pointer past source0 so a post-reset grant exposes rr reset.
    start_scn();
    add_pkt(0, 1, 8'hE0, 1'b0);
    build_exp();
    finish_scn("pre_rst");

    // Reset mid-packet after one payload byte, then restart.
    start_scn();
    add_pkt(0, 3, 8'h70, 1'b0);
    build_exp();
    guard = 0;
    while (act_q.size() < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_reached", 64'(guard < 200), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mtvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_tready", 64'(s_tready), 64'd0);
    chk("rst_mid_mtlast", 64'(m_tlast), 64'd0);
    chk("rst_mid_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      gap_left[i] = 0;
    end
    mid = '0;
    in_pkt = 1'b0;
    prev_stall = 1'b0;
    act_q.delete();
    exp_q.delete();
    m_rr = 0;
    add_pkt(0, 3, 8'h70, 1'b0);
    add_pkt(1, 2, 8'h90, 1'b0);
    build_exp();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    finish_scn("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
